// File: rtl/pbus_master.sv
// pbus_master: initiator for the shared peripheral register bus. CPU requests are
//   queued in an in-order FIFO and issued as one-cycle pbus accesses; read data
//   comes back on a valid/ready response port.
// Latency: a request accepted at edge N reaches the bus in cycle N+1 at the earliest.
//   Read data is valid from N+2. Writes issue one per cycle.
// Backpressure: req_ready = !full, and is 0 during reset. The FSM waits in RESP
//   until rsp_ready is seen, and no bus access is issued meanwhile.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   req_valid/req_ready                request handshake (push into FIFO)
//   req_we, req_addr, req_wdata        {write flag, {periph idx, reg offset}, data}
//   rsp_valid/rsp_ready, rsp_data      read response handshake and data
//   sel                                one-hot peripheral select (ACCESS cycle only)
//   pbus_we, pbus_addr                 bus write strobe and register offset
//   pbus_data                          tri-state data, driven only while pbus_we=1
module pbus_master #(
  parameter int DATA_N     = 8,
  parameter int REG_N      = 4,
  parameter int PERIPH_N   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [REG_N+1:0]    req_addr,
  input  logic [DATA_N-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_N-1:0]   rsp_data,
  output logic [PERIPH_N-1:0] sel,
  output logic                pbus_we,
  output logic [REG_N-1:0]    pbus_addr,
  inout  wire  [DATA_N-1:0]   pbus_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // One extra pointer bit separates full from empty when the indices are equal.
  localparam int PW = AW + 1;

  typedef struct packed {
    logic              we;
    logic [REG_N+1:0]  addr;
    logic [DATA_N-1:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_TURN   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  entry_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   count;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  entry_t          head;

  state_t          state_q;
  state_t          state_d;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == PW'(FIFO_DEPTH));
  // Occupancy only: a pop in the same cycle does not open a slot early.
  assign req_ready = !full && !reset;
  assign push      = req_valid && req_ready;
  // The head entry is consumed by its single ACCESS cycle.
  assign pop       = (state_q == ST_ACCESS);
  assign head      = fifo_mem[rd_ptr[AW-1:0]];

  // Storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Head entry decode
  // ---------------------------------------------------------------------------
  logic [1:0]        head_idx;
  logic [REG_N-1:0]  head_off;
  logic              head_in_range;
  logic              in_access;
  logic              drive_data;

  assign head_idx      = head.addr[REG_N+1:REG_N];
  assign head_off      = head.addr[REG_N-1:0];
  assign head_in_range = (int'(head_idx) < PERIPH_N);
  assign in_access     = (state_q == ST_ACCESS);
  assign drive_data    = in_access && head.we;

  // ---------------------------------------------------------------------------
  // Access FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (head.we) begin
          // count still includes the entry being popped, so >1 means another
          // entry was already queued. Anything pushed this very cycle goes
          // through IDLE first, which keeps the one-cycle minimum latency.
          state_d = (count > PW'(1)) ? ST_ACCESS : ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (empty) begin
            state_d = ST_IDLE;
          end else if (head.we) begin
            // Leave one dead bus cycle so the peripheral releases pbus_data
            // before the master starts driving it.
            state_d = ST_TURN;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_TURN: begin
        state_d = ST_ACCESS;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus outputs: only the ACCESS cycle presents anything on the bus
  // ---------------------------------------------------------------------------
  always_comb begin
    sel = '0;
    if (in_access) begin
      for (int i = 0; i < PERIPH_N; i++) begin
        if (int'(head_idx) == i) begin
          sel[i] = 1'b1;
        end
      end
    end
  end

  assign pbus_we   = drive_data;
  assign pbus_addr = in_access ? head_off : '0;
  assign pbus_data = drive_data ? head.wdata : 'z;

  // ---------------------------------------------------------------------------
  // Read response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data <= '0;
    end else if (in_access && !head.we) begin
      // No peripheral answers an out-of-range index, so return zero rather
      // than whatever the floating bus reads as.
      rsp_data <= head_in_range ? pbus_data : '0;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);

endmodule
